// File: rtl/axi_stream_interconnect_m2s_auto_head.sv
// Round-robin many-to-one AXI-stream packet mux that prefixes every packet with a
// HEAD_DUMMY-word big-endian header carrying the winning source index.
module axi_stream_interconnect_m2s_auto_head #(
    parameter int HEAD_DUMMY = 4,
    parameter int NUM        = 4,
    parameter int DSIZE      = 8
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NUM-1:0][DSIZE-1:0]     sub_rx_axis_tdata,
    input  logic [NUM-1:0]                sub_rx_axis_tvalid,
    output logic [NUM-1:0]                sub_rx_axis_tready,
    input  logic [NUM-1:0]                sub_rx_axis_tlast,
    output logic [DSIZE-1:0]              master_axis_tdata,
    output logic                          master_axis_tvalid,
    input  logic                          master_axis_tready,
    output logic                          master_axis_tlast,
    output logic [(DSIZE+7)/8-1:0]        master_axis_tkeep,
    output logic                          master_axis_tuser
);
    localparam int GW = $clog2(NUM);
    localparam int HW = $clog2(HEAD_DUMMY + 1);
    localparam int HB = DSIZE * HEAD_DUMMY;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HEAD = 2'd1;
    localparam logic [1:0] S_BODY = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [HW-1:0] hcnt_q, hcnt_d;

    logic          found_hi, found_lo;
    logic [GW-1:0] pick_hi, pick_lo, pick;
    logic [HB-1:0] hdr, hdr_sh;
    logic          body_hs;

    // Two-pass search: first valid index above last_grant, else the lowest valid index.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int j = 0; j < NUM; j++) begin
            if (!found_hi && sub_rx_axis_tvalid[j] && (GW'(j) > last_grant_q)) begin
                found_hi = 1'b1;
                pick_hi  = GW'(j);
            end
            if (!found_lo && sub_rx_axis_tvalid[j]) begin
                found_lo = 1'b1;
                pick_lo  = GW'(j);
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    // Header is the grant zero-extended over HB bits, emitted MSB word first.
    always_comb begin
        hdr          = '0;
        hdr[GW-1:0]  = grant_q;
        hdr_sh       = hdr >> (DSIZE * (HEAD_DUMMY - 1 - int'(hcnt_q)));
    end

    always_comb begin
        master_axis_tdata  = '0;
        master_axis_tvalid = 1'b0;
        master_axis_tlast  = 1'b0;
        master_axis_tkeep  = '1;
        master_axis_tuser  = 1'b0;
        sub_rx_axis_tready = '0;
        case (state_q)
            S_HEAD: begin
                master_axis_tvalid = 1'b1;
                master_axis_tdata  = hdr_sh[DSIZE-1:0];
            end
            S_BODY: begin
                master_axis_tdata           = sub_rx_axis_tdata[grant_q];
                master_axis_tvalid          = sub_rx_axis_tvalid[grant_q];
                master_axis_tlast           = sub_rx_axis_tlast[grant_q];
                sub_rx_axis_tready[grant_q] = master_axis_tready;
            end
            default: ;
        endcase
    end

    assign body_hs = sub_rx_axis_tvalid[grant_q] & master_axis_tready & sub_rx_axis_tlast[grant_q];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        hcnt_d       = hcnt_q;
        case (state_q)
            S_IDLE: begin
                hcnt_d = '0;
                if (|sub_rx_axis_tvalid) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    state_d      = S_HEAD;
                end
            end
            S_HEAD: begin
                if (master_axis_tready) begin
                    hcnt_d = hcnt_q + 1'b1;
                    if (hcnt_q == HW'(HEAD_DUMMY - 1))
                        state_d = S_BODY;
                end
            end
            S_BODY: begin
                if (body_hs)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM - 1);
            hcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            hcnt_q       <= hcnt_d;
        end
    end
endmodule

// File: doc/axi_stream_interconnect_m2s_auto_head.md
# axi_stream_interconnect_M2S_auto_head

Many-to-one AXI-stream packet interconnect with source tagging. It arbitrates NUM upstream packet streams round-robin onto one downstream stream. In front of each forwarded packet it inserts a header of HEAD_DUMMY words carrying the winning source index. A downstream auto-routing demultiplexer reads that header field, strips it and steers the packet back to output index NUM-1..0, so packets from a fan-in can cross one shared link and be redistributed at the far end.

## Interface
- HEAD_DUMMY, 4, header length in DSIZE words (≥1).
- NUM, 4, number of upstream streams (≥2; $clog2(NUM) ≤ DSIZE*HEAD_DUMMY).
- DSIZE, taken from master.DSIZE; all sub_rx_inf[i].DSIZE must be equal.
- aclk  input  1  clock; all logic is on the rising edge.
- aresetn  input  1  reset, asynchronous and active-low.
- sub_rx_inf  axi_stream_inf.slaver  [NUM-1:0]  upstream packet streams; uses axis_tdata, axis_tvalid, axis_tready and axis_tlast.
- master  axi_stream_inf.master  1  tagged downstream stream; drives axis_tdata, axis_tvalid and axis_tlast, and samples axis_tready.
- All interfaces share aclk/aresetn. axis_tkeep and axis_tuser are not used. master.axis_tkeep is driven to all-ones and master.axis_tuser to 0.

## Operation
- The FSM has three states: IDLE, HEAD and BODY. The reset state is IDLE.
- IDLE:
  - The block watches for any sub_rx_inf[i].axis_tvalid.
  - Selection is round-robin. Search starts at (last_grant+1) mod NUM and takes the first valid index.
  - On that edge: grant ← index, last_grant ← index, hcnt ← 0, state → HEAD.
  - The block does not stay in IDLE when any valid is present.
- HEAD:
  - master.axis_tvalid = 1 and master.axis_tlast = 0.
  - Header data is big-endian over DSIZE*HEAD_DUMMY bits. The field value is the grant, zero-extended.
  - Word hcnt < HEAD_DUMMY-1 is 0 (MSB words). Word HEAD_DUMMY-1 is the grant in its low $clog2(NUM) bits, with all other bits 0.
  - hcnt increments on each master handshake (valid & ready).
  - After the handshake of word HEAD_DUMMY-1: state → BODY.
  - All sub_rx_inf.axis_tready = 0 in this state; no source beats are consumed.
- BODY:
  - The granted source passes through combinationally:
    - master.axis_tdata/tvalid/tlast = sub_rx_inf[grant] signals.
    - sub_rx_inf[grant].axis_tready = master.axis_tready.
  - Non-granted sources have tready = 0.
  - On a handshake with tlast = 1: state → IDLE.
  - Source bubbles (tvalid low) are passed through unchanged; the lock is held until tlast.
- Single-beat packets are legal: HEAD_DUMMY header beats plus 1 data beat.
- Fairness: after a packet from i, source i has the lowest priority at the next arbitration.

## Timing
- Reset values:
  - state = IDLE, last_grant = NUM-1 (so index 0 wins first), grant = 0, hcnt = 0.
  - master.axis_tvalid = 0, tlast = 0, tdata = 0.
  - All sub_rx_inf.axis_tready = 0.
- Latency: source tvalid seen in IDLE at edge k means the first header word is valid at cycle k+1. With ready held high, the first payload beat is on master at cycle k+1+HEAD_DUMMY.
- Throughput: one idle cycle between packets (the IDLE arbitration cycle). Header beats cost HEAD_DUMMY cycles per packet. Body runs at 1 beat/cycle.
- master.axis_tready low in HEAD: the header word and hcnt hold, and tvalid stays 1 (AXI-stream rule: valid is never withdrawn).
- master.axis_tready low in BODY: backpressure passes straight to the granted source.
- A source that asserts valid while another packet is in progress is served in a later IDLE cycle in round-robin order. Its data must stay stable, per the AXI-stream rule.
- Reset asserted mid-packet: everything returns to reset values asynchronously. The partial packet is truncated downstream without tlast; this is the system's responsibility.
- hcnt width is $clog2(HEAD_DUMMY+1). Header index compare wraps never occur, since hcnt clears in IDLE.

## Test plan
- NUM=4, HEAD_DUMMY=4, DSIZE=8, ready high. Source 2 sends 3 beats A1,A2,A3 (tlast on A3) → master carries 00,00,00,02,A1,A2,A3. tlast only on A3. First header word is at cycle k+1 after valid.
- All 4 sources valid continuously, each packet 2 beats → grant order 0,1,2,3,0,… Header last words 00,01,02,03. One IDLE cycle between packets.
- master.axis_tready toggles 1,0,0,1 during HEAD and BODY → no header word is dropped or duplicated. Source tready mirrors master tready only in BODY. Total handshakes equal HEAD_DUMMY+length.
- Single-beat packet on source 3 with HEAD_DUMMY=1 → master carries 03 then the data beat with tlast. Back in IDLE after 2 handshakes.
- Assert aresetn low during BODY of a packet from source 1 → tvalid 0 and all treadys 0 immediately. After release, source 1 and source 0 both valid → source 0 wins (last_grant = 3).
- Loopback through the matching downstream auto demultiplexer with random packets from 4 sources → every packet arrives intact on the output matching its source index.
